// File: rtl/rf_issue_ctrl.sv
// ----------------------------------------------------------------------------
// rf_issue_ctrl
//
// Issue stage sitting between instruction fetch and the register bank.
// It accepts one 16-bit instruction at a time, decodes it, drives the bank's
// toggle-strobe request interface and, for reads, waits for the bank's
// response toggle before handing the operands to the ALU over a valid/ready
// handshake. Only one instruction is ever in flight.
//
// Instruction format: [15:12] opcode, [11:9] RA, [8:6] RB, [7:0] IMM
// Opcodes: 0 NOP, 1 LI (RA <= IMM), 2 RR (read RA,RB), 3 R1 (read RA),
//          anything else is illegal.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous reset, active-high
//   instr_valid_i      fetch presents an instruction
//   instr_ready_o      issue can accept (only in IDLE)
//   instr_i            instruction word
//   rf_li_controler_o  bank strobe, every level change is one request
//   rf_operation_o     00 write, 01 read RA+RB, 10 read RA, 11 idle
//   rf_index_0_o       RA
//   rf_index_1_o       RB
//   rf_data_in_o       write data (IMM)
//   rf_data_out_0_i    bank read data A
//   rf_data_out_1_i    bank read data B
//   rf_response_i      bank completion, toggles once per read
//   op_valid_o         operands valid for the ALU
//   op_ready_i         ALU accepts operands
//   op_code_o          opcode of the issued instruction
//   op_dest_o          RA of the issued instruction
//   op_a_o             operand A
//   op_b_o             operand B (0 for a single-register read)
//   err_o              one-cycle pulse: illegal opcode or read timeout
//   busy_o             high whenever the controller is not IDLE
// ----------------------------------------------------------------------------
module rf_issue_ctrl #(
    parameter int unsigned WR_HOLD    = 2,
    parameter int unsigned RD_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [15:0] instr_i,
    output logic        rf_li_controler_o,
    output logic [1:0]  rf_operation_o,
    output logic [2:0]  rf_index_0_o,
    output logic [2:0]  rf_index_1_o,
    output logic [7:0]  rf_data_in_o,
    input  logic [7:0]  rf_data_out_0_i,
    input  logic [7:0]  rf_data_out_1_i,
    input  logic        rf_response_i,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic [3:0]  op_code_o,
    output logic [2:0]  op_dest_o,
    output logic [7:0]  op_a_o,
    output logic [7:0]  op_b_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_LI  = 4'h1;
    localparam logic [3:0] OPC_RR  = 4'h2;
    localparam logic [3:0] OPC_R1  = 4'h3;

    localparam logic [1:0] RF_WRITE   = 2'b00;
    localparam logic [1:0] RF_READ_AB = 2'b01;
    localparam logic [1:0] RF_READ_A  = 2'b10;
    localparam logic [1:0] RF_IDLE    = 2'b11;

    // Terminal counts for the shared cycle counter (8 bits covers both ranges).
    localparam logic [7:0] WR_LAST = 8'(WR_HOLD - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_WR,
        WAIT_RD,
        OUT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        resp_last_q, resp_last_d;
    logic        strobe_q, strobe_d;
    logic [1:0]  rf_op_q, rf_op_d;
    logic [2:0]  idx0_q, idx0_d;
    logic [2:0]  idx1_q, idx1_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        op_valid_q, op_valid_d;
    logic [3:0]  op_code_q, op_code_d;
    logic [2:0]  op_dest_q, op_dest_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic        err_q, err_d;

    logic        accept;
    logic [3:0]  opc_in;
    logic [3:0]  opc_latched;
    logic        in_is_issue;
    logic        in_is_illegal;
    logic        resp_toggled;

    // Decode helpers shared by the next-state and output logic. The incoming
    // opcode decides NOP/illegal handling at accept time; everything after
    // that works from the latched copy.
    always_comb begin
        accept        = instr_valid_i && (state_q == IDLE);
        opc_in        = instr_i[15:12];
        opc_latched   = instr_q[15:12];
        in_is_issue   = (opc_in == OPC_LI) || (opc_in == OPC_RR) || (opc_in == OPC_R1);
        in_is_illegal = !in_is_issue && (opc_in != OPC_NOP);
        resp_toggled  = (rf_response_i != resp_last_q);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In WAIT_RD a response arriving on the same cycle the
    // timeout expires takes priority, so a slow-but-valid read is never lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && in_is_issue) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                state_d = (opc_latched == OPC_LI) ? WAIT_WR : WAIT_RD;
            end
            WAIT_WR: begin
                if (cnt_q == WR_LAST) begin
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                if (resp_toggled) begin
                    state_d = OUT;
                end else if (cnt_q == RD_LAST) begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (op_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / datapath next-state logic. Every register holds by default;
    // err is a pulse so it defaults low. The bank fields are registered in
    // SETUP and only toggled in STROBE, which gives the bank one full cycle
    // of stable fields before the request edge.
    always_comb begin
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        resp_last_d = resp_last_q;
        strobe_d    = strobe_q;
        rf_op_d     = rf_op_q;
        idx0_d      = idx0_q;
        idx1_d      = idx1_q;
        wdata_d     = wdata_q;
        op_valid_d  = op_valid_q;
        op_code_d   = op_code_q;
        op_dest_d   = op_dest_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // The bank's response flop is not reset, so its level is
                // tracked continuously here; stray toggles are absorbed too.
                resp_last_d = rf_response_i;
                rf_op_d     = RF_IDLE;
                if (accept) begin
                    instr_d = instr_i;
                    if (in_is_illegal) begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                case (opc_latched)
                    OPC_LI:  rf_op_d = RF_WRITE;
                    OPC_RR:  rf_op_d = RF_READ_AB;
                    OPC_R1:  rf_op_d = RF_READ_A;
                    default: rf_op_d = RF_IDLE;
                endcase
                idx0_d  = instr_q[11:9];
                idx1_d  = instr_q[8:6];
                wdata_d = instr_q[7:0];
            end
            STROBE: begin
                strobe_d = ~strobe_q;
                cnt_d    = 8'd0;
            end
            WAIT_WR: begin
                // The bank gives no write acknowledge, so fields are simply
                // held for a fixed number of cycles.
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WR_LAST) begin
                    rf_op_d = RF_IDLE;
                end
            end
            WAIT_RD: begin
                if (resp_toggled) begin
                    resp_last_d = rf_response_i;
                    op_valid_d  = 1'b1;
                    op_code_d   = opc_latched;
                    op_dest_d   = instr_q[11:9];
                    op_a_d      = rf_data_out_0_i;
                    op_b_d      = (opc_latched == OPC_RR) ? rf_data_out_1_i : 8'd0;
                end else if (cnt_q == RD_LAST) begin
                    err_d   = 1'b1;
                    rf_op_d = RF_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            OUT: begin
                if (op_ready_i) begin
                    op_valid_d = 1'b0;
                    rf_op_d    = RF_IDLE;
                end
            end
            default: begin
                rf_op_d = RF_IDLE;
            end
        endcase
    end

    // Datapath registers. An asynchronous reset drops any in-flight
    // instruction; the strobe and the operation return to their idle values
    // together, so a reset-induced strobe edge is seen with operation 11.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q     <= 16'd0;
            cnt_q       <= 8'd0;
            resp_last_q <= 1'b0;
            strobe_q    <= 1'b0;
            rf_op_q     <= RF_IDLE;
            idx0_q      <= 3'd0;
            idx1_q      <= 3'd0;
            wdata_q     <= 8'd0;
            op_valid_q  <= 1'b0;
            op_code_q   <= 4'd0;
            op_dest_q   <= 3'd0;
            op_a_q      <= 8'd0;
            op_b_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            resp_last_q <= resp_last_d;
            strobe_q    <= strobe_d;
            rf_op_q     <= rf_op_d;
            idx0_q      <= idx0_d;
            idx1_q      <= idx1_d;
            wdata_q     <= wdata_d;
            op_valid_q  <= op_valid_d;
            op_code_q   <= op_code_d;
            op_dest_q   <= op_dest_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            err_q       <= err_d;
        end
    end

    // Output mapping; ready and busy are decoded straight from the state.
    always_comb begin
        instr_ready_o     = (state_q == IDLE);
        busy_o            = (state_q != IDLE);
        rf_li_controler_o = strobe_q;
        rf_operation_o    = rf_op_q;
        rf_index_0_o      = idx0_q;
        rf_index_1_o      = idx1_q;
        rf_data_in_o      = wdata_q;
        op_valid_o        = op_valid_q;
        op_code_o         = op_code_q;
        op_dest_o         = op_dest_q;
        op_a_o            = op_a_q;
        op_b_o            = op_b_q;
        err_o             = err_q;
    end

endmodule

// File: tb/tb_rf_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rf_issue_ctrl
//
// Bench for rf_issue_ctrl with a zero-delay register bank model. Expected
// ALU operands are queued when a read instruction is issued and popped when
// the DUT raises op_valid. All sampling happens on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_rf_issue_ctrl;

    localparam int unsigned WR_HOLD    = 2;
    localparam int unsigned RD_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        instrValid;
    logic        instr_ready_o;
    logic [15:0] instrIn;
    logic        rf_li_controler_o;
    logic [1:0]  rf_operation_o;
    logic [2:0]  rf_index_0_o;
    logic [2:0]  rf_index_1_o;
    logic [7:0]  rf_data_in_o;
    logic [7:0]  bankOut0;
    logic [7:0]  bankOut1;
    logic        bankResp;
    logic        op_valid_o;
    logic        opReady;
    logic [3:0]  op_code_o;
    logic [2:0]  op_dest_o;
    logic [7:0]  op_a_o;
    logic [7:0]  op_b_o;
    logic        err_o;
    logic        busy_o;

    typedef struct {
        logic [3:0] code;
        logic [2:0] dest;
        logic [7:0] a;
        logic [7:0] b;
    } opExp_t;

    opExp_t expQ[$];

    int errors = 0;
    int checks = 0;

    logic [7:0] bankRegs [8];
    logic       withhold;
    int         strobeCount;

    localparam logic [43:0] RESET_VIEW = {1'b1, 1'b0, 2'b11, 3'd0, 3'd0, 8'd0,
                                          1'b0, 4'd0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    logic [43:0] outView;

    assign outView = {instr_ready_o, rf_li_controler_o, rf_operation_o, rf_index_0_o,
                      rf_index_1_o, rf_data_in_o, op_valid_o, op_code_o, op_dest_o,
                      op_a_o, op_b_o, err_o, busy_o};

    rf_issue_ctrl #(
        .WR_HOLD    (WR_HOLD),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_valid_i     (instrValid),
        .instr_ready_o     (instr_ready_o),
        .instr_i           (instrIn),
        .rf_li_controler_o (rf_li_controler_o),
        .rf_operation_o    (rf_operation_o),
        .rf_index_0_o      (rf_index_0_o),
        .rf_index_1_o      (rf_index_1_o),
        .rf_data_in_o      (rf_data_in_o),
        .rf_data_out_0_i   (bankOut0),
        .rf_data_out_1_i   (bankOut1),
        .rf_response_i     (bankResp),
        .op_valid_o        (op_valid_o),
        .op_ready_i        (opReady),
        .op_code_o         (op_code_o),
        .op_dest_o         (op_dest_o),
        .op_a_o            (op_a_o),
        .op_b_o            (op_b_o),
        .err_o             (err_o),
        .busy_o            (busy_o)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank model: acts on every strobe level change unless the
    // operation is idle. Its response flop is never reset. For single reads
    // port B shows junk so a non-zeroed operand B would be visible.
    initial begin
        for (int i = 0; i < 8; i++) bankRegs[i] = 8'd0;
        bankResp    = 1'b0;
        bankOut0    = 8'd0;
        bankOut1    = 8'd0;
        withhold    = 1'b0;
        strobeCount = 0;
    end

    always @(rf_li_controler_o) begin
        strobeCount = strobeCount + 1;
        if (rf_operation_o == 2'b00) begin
            bankRegs[rf_index_0_o] = rf_data_in_o;
        end else if (rf_operation_o == 2'b01 || rf_operation_o == 2'b10) begin
            bankOut0 = bankRegs[rf_index_0_o];
            bankOut1 = (rf_operation_o == 2'b01) ? bankRegs[rf_index_1_o] : 8'hEE;
            if (!withhold) bankResp = ~bankResp;
        end
    end

    // Safety net in case something hangs outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one instruction at a falling edge and returns at the falling
    // edge after it was accepted (n0).
    task automatic applyStimulus(input logic [15:0] instr);
        int waitCycles;
        waitCycles = 0;
        while (!instr_ready_o && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL issue_wait: instr_ready=%b required 1", instr_ready_o);
        end
        instrIn    = instr;
        instrValid = 1'b1;
        @(negedge clk);
        instrValid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        instrValid = 1'b0;
        instrIn    = 16'd0;
        opReady    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outView !== RESET_VIEW) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required %h", outView, RESET_VIEW);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outView !== RESET_VIEW) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h required %h", outView, RESET_VIEW);
        end
    endtask

    task automatic test_li();
        int s0;
        int busyCycles;
        int toggleAt;
        bit sawValid;
        bit sawErr;
        logic [1:0] opAtToggle;
        logic [2:0] idxAtToggle;
        logic [7:0] dataAtToggle;
        busyCycles   = 0;
        toggleAt     = -1;
        sawValid     = 0;
        sawErr       = 0;
        opAtToggle   = 2'bxx;
        idxAtToggle  = 3'bxxx;
        dataAtToggle = 8'hxx;
        s0 = strobeCount;
        applyStimulus(16'h165A);
        for (int i = 0; i < 20; i++) begin
            if (busy_o) busyCycles++;
            if (toggleAt < 0 && strobeCount != s0) begin
                toggleAt     = i;
                opAtToggle   = rf_operation_o;
                idxAtToggle  = rf_index_0_o;
                dataAtToggle = rf_data_in_o;
            end
            sawValid |= op_valid_o;
            sawErr   |= err_o;
            if (!busy_o) break;
            @(negedge clk);
        end
        checks++;
        if (busyCycles != 2 + WR_HOLD) begin
            errors++;
            $display("[TB] FAIL li_busy_cycles: got %0d required %0d", busyCycles, 2 + WR_HOLD);
        end
        checks++;
        if (toggleAt != 2) begin
            errors++;
            $display("[TB] FAIL li_strobe_time: got %0d required 2", toggleAt);
        end
        checks++;
        if (strobeCount - s0 != 1) begin
            errors++;
            $display("[TB] FAIL li_strobe_count: got %0d required 1", strobeCount - s0);
        end
        checks++;
        if ({opAtToggle, idxAtToggle, dataAtToggle} !== {2'b00, 3'd3, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL li_fields: got op=%b idx=%0d data=%h required op=00 idx=3 data=5a",
                     opAtToggle, idxAtToggle, dataAtToggle);
        end
        checks++;
        if (bankRegs[3] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL li_bank_write: got %h required 5a", bankRegs[3]);
        end
        checks++;
        if (sawValid || sawErr) begin
            errors++;
            $display("[TB] FAIL li_no_valid_err: got valid=%b err=%b required 0 0", sawValid, sawErr);
        end
        checks++;
        if (rf_operation_o !== 2'b11) begin
            errors++;
            $display("[TB] FAIL li_op_idle: got %b required 11", rf_operation_o);
        end
    endtask

    task automatic test_rr();
        int validAt;
        opExp_t e;
        applyStimulus(16'h1211);
        applyStimulus(16'h1422);
        opReady = 1'b1;
        expQ.push_back('{4'h2, 3'd1, 8'h11, 8'h22});
        applyStimulus(16'h2280);
        validAt = -1;
        for (int i = 0; i < 30; i++) begin
            if (op_valid_o) begin
                validAt = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (validAt != 3) begin
            errors++;
            $display("[TB] FAIL rr_valid_time: got %0d required 3", validAt);
        end
        e = expQ.pop_front();
        if (validAt >= 0) begin
            checks++;
            if ({op_code_o, op_dest_o} !== {e.code, e.dest}) begin
                errors++;
                $display("[TB] FAIL rr_code_dest: got %h/%0d required %h/%0d",
                         op_code_o, op_dest_o, e.code, e.dest);
            end
            checks++;
            if ({op_a_o, op_b_o} !== {e.a, e.b}) begin
                errors++;
                $display("[TB] FAIL rr_operands: got a=%h b=%h required a=%h b=%h",
                         op_a_o, op_b_o, e.a, e.b);
            end
        end
        @(negedge clk);
        checks++;
        if ({op_valid_o, instr_ready_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rr_after_handshake: got valid=%b ready=%b required 0 1",
                     op_valid_o, instr_ready_o);
        end
    endtask

    task automatic test_backpressure();
        int validAt;
        opExp_t e;
        opReady = 1'b0;
        expQ.push_back('{4'h3, 3'd2, 8'h22, 8'h00});
        applyStimulus(16'h3400);
        validAt = -1;
        for (int i = 0; i < 30; i++) begin
            if (op_valid_o) begin
                validAt = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (validAt != 3) begin
            errors++;
            $display("[TB] FAIL bp_valid_time: got %0d required 3", validAt);
        end
        e = expQ.pop_front();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({op_valid_o, instr_ready_o, op_code_o, op_dest_o, op_a_o, op_b_o} !==
                {1'b1, 1'b0, e.code, e.dest, e.a, e.b}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: got v=%b r=%b c=%h d=%0d a=%h b=%h required v=1 r=0 c=%h d=%0d a=%h b=%h",
                         k, op_valid_o, instr_ready_o, op_code_o, op_dest_o, op_a_o, op_b_o,
                         e.code, e.dest, e.a, e.b);
            end
            @(negedge clk);
        end
        opReady = 1'b1;
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_ready_during_handshake: got %b required 0", instr_ready_o);
        end
        @(negedge clk);
        checks++;
        if ({op_valid_o, instr_ready_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_after_handshake: got valid=%b ready=%b required 0 1",
                     op_valid_o, instr_ready_o);
        end
    endtask

    task automatic test_timeout();
        int s0;
        int errAt;
        int errCount;
        bit sawValid;
        errAt    = -1;
        errCount = 0;
        sawValid = 0;
        withhold = 1'b1;
        s0 = strobeCount;
        applyStimulus(16'h3200);
        for (int i = 0; i < int'(2 + RD_TIMEOUT + 6); i++) begin
            if (err_o) begin
                errCount++;
                if (errAt < 0) errAt = i;
            end
            sawValid |= op_valid_o;
            @(negedge clk);
        end
        withhold = 1'b0;
        checks++;
        if (errAt != int'(2 + RD_TIMEOUT)) begin
            errors++;
            $display("[TB] FAIL to_err_time: got %0d required %0d", errAt, 2 + RD_TIMEOUT);
        end
        checks++;
        if (errCount != 1) begin
            errors++;
            $display("[TB] FAIL to_err_width: got %0d required 1", errCount);
        end
        checks++;
        if (sawValid) begin
            errors++;
            $display("[TB] FAIL to_no_valid: got %b required 0", sawValid);
        end
        checks++;
        if ({busy_o, rf_operation_o} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL to_idle: got busy=%b op=%b required 0 11", busy_o, rf_operation_o);
        end
        checks++;
        if (strobeCount - s0 != 1) begin
            errors++;
            $display("[TB] FAIL to_strobe_count: got %0d required 1", strobeCount - s0);
        end
    endtask

    task automatic test_illegal_nop();
        int s0;
        bit sawErr;
        s0 = strobeCount;
        applyStimulus(16'hF000);
        checks++;
        if ({err_o, busy_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ill_err: got err=%b busy=%b required 1 0", err_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if ({err_o, instr_ready_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ill_err_clear: got err=%b ready=%b required 0 1", err_o, instr_ready_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (strobeCount != s0) begin
            errors++;
            $display("[TB] FAIL ill_no_strobe: got %0d toggles required 0", strobeCount - s0);
        end
        sawErr = 0;
        applyStimulus(16'h0000);
        for (int i = 0; i < 3; i++) begin
            sawErr |= err_o;
            checks++;
            if ({instr_ready_o, busy_o} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL nop_idle_%0d: got ready=%b busy=%b required 1 0",
                         i, instr_ready_o, busy_o);
            end
            @(negedge clk);
        end
        checks++;
        if (sawErr || strobeCount != s0) begin
            errors++;
            $display("[TB] FAIL nop_quiet: got err=%b toggles=%0d required 0 0", sawErr, strobeCount - s0);
        end
    endtask

    task automatic test_reset_mid();
        int validAt;
        opExp_t e;
        // Stray responses while idle must be absorbed; end with bank level 1.
        bankResp = ~bankResp;
        repeat (2) @(negedge clk);
        if (!bankResp) begin
            bankResp = 1'b1;
            repeat (2) @(negedge clk);
        end
        checks++;
        if ({busy_o, op_valid_o, err_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL stray_resp: got busy=%b valid=%b err=%b required 0 0 0",
                     busy_o, op_valid_o, err_o);
        end
        withhold = 1'b1;
        applyStimulus(16'h3200);
        repeat (2) @(negedge clk);
        checks++;
        if ({rf_li_controler_o, busy_o} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rm_strobe_high: got strobe=%b busy=%b required 1 1",
                     rf_li_controler_o, busy_o);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (outView !== RESET_VIEW) begin
            errors++;
            $display("[TB] FAIL rm_async_reset: got %h required %h", outView, RESET_VIEW);
        end
        @(negedge clk);
        rst      = 1'b0;
        withhold = 1'b0;
        @(negedge clk);
        checks++;
        if (outView !== RESET_VIEW) begin
            errors++;
            $display("[TB] FAIL rm_post_reset: got %h required %h", outView, RESET_VIEW);
        end
        opReady = 1'b1;
        expQ.push_back('{4'h2, 3'd1, 8'h11, 8'h22});
        applyStimulus(16'h2280);
        validAt = -1;
        for (int i = 0; i < 30; i++) begin
            if (op_valid_o) begin
                validAt = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (validAt != 3) begin
            errors++;
            $display("[TB] FAIL rm_rr_valid_time: got %0d required 3", validAt);
        end
        e = expQ.pop_front();
        if (validAt >= 0) begin
            checks++;
            if ({op_code_o, op_dest_o, op_a_o, op_b_o} !== {e.code, e.dest, e.a, e.b}) begin
                errors++;
                $display("[TB] FAIL rm_rr_operands: got c=%h d=%0d a=%h b=%h required c=%h d=%0d a=%h b=%h",
                         op_code_o, op_dest_o, op_a_o, op_b_o, e.code, e.dest, e.a, e.b);
            end
        end
        @(negedge clk);
        checks++;
        if ({op_valid_o, err_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rm_rr_done: got valid=%b err=%b required 0 0", op_valid_o, err_o);
        end
    endtask

    // Scenario sequence; each task leaves the bench at a falling edge.
    initial begin
        rst        = 1'b1;
        instrValid = 1'b0;
        instrIn    = 16'd0;
        opReady    = 1'b0;
        test_reset();
        test_li();
        test_rr();
        test_backpressure();
        test_timeout();
        test_illegal_nop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
